// File: rtl/trace_line_parser_if.sv
// Byte-stream input and record-output handshake of the trace line parser.
// The parser itself connects through the slave modport; the byte source and
// record consumer side connects through the master modport.
interface trace_line_parser_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              eof;
  logic              rec_valid;
  logic              rec_ready;
  logic [ADDR_W-1:0] rec_addr;
  logic              rec_write;

  modport master (
    output in_valid, in_byte, eof, rec_ready,
    input  rec_valid, rec_addr, rec_write
  );

  modport slave (
    input  in_valid, in_byte, eof, rec_ready,
    output rec_valid, rec_addr, rec_write
  );
endinterface

// File: rtl/trace_line_parser.sv
// Parses ASCII trace lines "<op><ws><hexaddr>\n" into {addr, write} records,
// buffers them in a small FIFO and counts good/malformed lines.
// ADDR_W must be a multiple of 4 and at least 8.
module trace_line_parser #(
  parameter int ADDR_W  = 32,
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  trace_line_parser_if.slave   bus,
  output logic [15:0]          line_cnt,
  output logic [7:0]           err_cnt,
  output logic                 overflow
);
  localparam int NDIG   = ADDR_W / 4;
  localparam int NDIG_W = $clog2(NDIG + 1);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int CNT_W  = FIFO_AW + 1;
  localparam int REC_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_START, ST_SEP, ST_HEX_WAIT, ST_HEX, ST_TAIL, ST_SKIP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   acc_q, acc_d;
  logic [NDIG_W-1:0]   ndig_q, ndig_d;
  logic                op_q, op_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [15:0]         line_cnt_q, line_cnt_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                overflow_q, overflow_d;
  logic [REC_W-1:0]    mem_q [DEPTH];

  logic [7:0]          b;
  logic                is_ws, is_nl, is_rd, is_wr, is_hex;
  logic [3:0]          hex_val;
  logic                push, err, pop, full, push_ok, drop;
  logic [REC_W-1:0]    rec_d;

  assign b     = bus.in_byte;
  assign is_ws = (b == 8'h20) || (b == 8'h09);
  assign is_nl = (b == 8'h0A);
  assign is_rd = (b == 8'h52) || (b == 8'h72) || (b == 8'h30);
  assign is_wr = (b == 8'h57) || (b == 8'h77) || (b == 8'h31);

  // Decode the incoming byte as a hex digit; letters map via low nibble + 9.
  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'h0;
    if (b >= 8'h30 && b <= 8'h39)      hex_val = b[3:0];
    else if (b >= 8'h61 && b <= 8'h66) hex_val = b[3:0] + 4'd9;
    else if (b >= 8'h41 && b <= 8'h46) hex_val = b[3:0] + 4'd9;
    else                               is_hex  = 1'b0;
  end

  // Next-state logic: byte first, then an eof in the same cycle flushes.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    op_d    = op_q;
    push    = 1'b0;
    err     = 1'b0;
    if (bus.in_valid && b != 8'h0D) begin
      unique case (state_q)
        ST_START: begin
          if (is_nl || is_ws) state_d = ST_START;
          else if (is_rd) begin op_d = 1'b0; state_d = ST_SEP; end
          else if (is_wr) begin op_d = 1'b1; state_d = ST_SEP; end
          else begin err = 1'b1; state_d = ST_SKIP; end
        end
        ST_SEP: begin
          if (is_ws) state_d = ST_HEX_WAIT;
          else begin err = 1'b1; state_d = is_nl ? ST_START : ST_SKIP; end
        end
        ST_HEX_WAIT: begin
          if (is_ws) state_d = ST_HEX_WAIT;
          else if (is_hex) begin
            acc_d   = {{(ADDR_W-4){1'b0}}, hex_val};
            ndig_d  = NDIG_W'(1);
            state_d = ST_HEX;
          end
          else begin err = 1'b1; state_d = is_nl ? ST_START : ST_SKIP; end
        end
        ST_HEX: begin
          if (is_hex) begin
            if (ndig_q < NDIG_W'(NDIG)) begin
              acc_d  = {acc_q[ADDR_W-5:0], hex_val};
              ndig_d = ndig_q + NDIG_W'(1);
            end else begin
              err = 1'b1; state_d = ST_SKIP;
            end
          end
          else if (is_ws) state_d = ST_TAIL;
          else if (is_nl) begin push = 1'b1; state_d = ST_START; end
          else begin err = 1'b1; state_d = ST_SKIP; end
        end
        ST_TAIL: begin
          if (is_ws) state_d = ST_TAIL;
          else if (is_nl) begin push = 1'b1; state_d = ST_START; end
          else begin err = 1'b1; state_d = ST_SKIP; end
        end
        ST_SKIP: begin
          if (is_nl) state_d = ST_START;
        end
        default: state_d = ST_START;
      endcase
    end
    if (bus.eof) begin
      if (state_d == ST_HEX || state_d == ST_TAIL) push = 1'b1;
      state_d = ST_START;
    end
  end

  // Output/FIFO control: head drives the record bus, push is dropped when full without a pop.
  always_comb begin
    rec_d         = {acc_d, op_d};
    bus.rec_valid = (count_q != '0);
    full          = (count_q == CNT_W'(DEPTH));
    pop           = bus.rec_valid && bus.rec_ready;
    push_ok       = push && (!full || pop);
    drop          = push && full && !pop;
    {bus.rec_addr, bus.rec_write} = mem_q[rd_ptr_q];
    wr_ptr_d      = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d       = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    line_cnt_d    = line_cnt_q + 16'(push_ok);
    err_cnt_d     = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    overflow_d    = overflow_q | drop;
  end

  assign line_cnt = line_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign overflow = overflow_q;

  // State register for the parser, FIFO pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      acc_q      <= '0;
      ndig_q     <= '0;
      op_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      line_cnt_q <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ndig_q     <= ndig_d;
      op_q       <= op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      line_cnt_q <= line_cnt_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // One register per FIFO entry; cleared on reset so the idle record bus reads zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (rst)                                     mem_q[gi] <= '0;
      else if (push_ok && wr_ptr_q == FIFO_AW'(gi)) mem_q[gi] <= rec_d;
    end
  end
endmodule
